key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/debounce_pkg.sv | 8 +
 rtl/debounce_bit.sv | 65 ++++++
 rtl/key_debounce.sv | 47 ++++
 tb/tb_key_debounce.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and widths for the key debouncer.
package debounce_pkg;
    localparam int DEF_WIDTH      = 5;
    localparam int DEF_SAMPLE_DIV = 50000;
    localparam int DEF_STABLE_CNT = 4;
    localparam int CNT_W          = 4;
    localparam int TICK_W         = 16;
endpackage

// File: rtl/debounce_bit.sv
// One debounced input: 2-flop synchronizer, stable counter, clean level, edge pulses.
// With DEBOUNCE_BYPASS_EN defined the clean level is just the synchronizer registered once.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic clean_d;

`ifdef DEBOUNCE_BYPASS_EN
    logic unused_tick;
    assign unused_tick = tick;

    always_ff @(posedge clk) begin
        if (rst) clean <= 1'b0;
        else     clean <= sync;
    end
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
    logic [CNT_W-1:0] stable;

    // Any sample that agrees with the current level restarts the qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            clean  <= 1'b0;
        end else if (tick) begin
            if (sync == clean) begin
                stable <= '0;
            end else if (stable == LAST) begin
                clean  <= sync;
                stable <= '0;
            end else begin
                stable <= stable + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            clean_d <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            meta    <= raw;
            sync    <= meta;
            clean_d <= clean;
            rise    <= clean & ~clean_d;
            fall    <= ~clean & clean_d;
        end
    end
endmodule

// File: rtl/key_debounce.sv
// Debouncer for WIDTH board switches sharing one sample-tick counter.
// DEBOUNCE_BYPASS_EN removes the tick counter and debounce, leaving sync + one register.
module key_debounce
    import debounce_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);
    logic tick;

`ifdef DEBOUNCE_BYPASS_EN
    assign tick = 1'b1;
`else
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    logic [TICK_W-1:0] tick_cnt;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        debounce_bit #(
            .STABLE_CNT(STABLE_CNT)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .raw  (raw_in[i]),
            .clean(clean_out[i]),
            .rise (rise_pulse[i]),
            .fall (fall_pulse[i])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with SAMPLE_DIV=4, STABLE_CNT=3, WIDTH=5.
// Cycle numbers count falling edges after the reset edge (or after the marked point).
module tb_key_debounce;
    localparam int W = 5;

`ifdef DEBOUNCE_BYPASS_EN
    localparam int LAT          = 3;
    localparam int BOUNCE_UP    = 23;
    localparam int BOUNCE_RISES = 3;
    localparam int GLITCH_RISES = 1;
    localparam int GLITCH_FALLS = 1;
    localparam int GLITCH_UP    = 15;
`else
    // first tick sees sync at edge 4, acceptance on the third tick (edge 12)
    localparam int LAT          = 12;
    localparam int BOUNCE_UP    = 32;
    localparam int BOUNCE_RISES = 1;
    localparam int GLITCH_RISES = 0;
    localparam int GLITCH_FALLS = 0;
    localparam int GLITCH_UP    = 24;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    int checks = 0;
    int errors = 0;

    int           cyc;
    int           up_at   [W];
    int           dn_at   [W];
    int           rise_hi [W];
    int           fall_hi [W];
    int           rise_at [W];
    int           fall_at [W];
    logic [W-1:0] prev_clean;
    logic [W-1:0] first_rise_vec;
    int           first_rise_cyc;

    key_debounce #(
        .WIDTH(W),
        .SAMPLE_DIV(4),
        .STABLE_CNT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_in(raw_in),
        .clean_out(clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic clear_mon();
        cyc = 0;
        for (int b = 0; b < W; b++) begin
            up_at[b] = -1; dn_at[b] = -1; rise_at[b] = -1; fall_at[b] = -1;
            rise_hi[b] = 0; fall_hi[b] = 0;
        end
        prev_clean     = clean_out;
        first_rise_vec = '0;
        first_rise_cyc = -1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            for (int b = 0; b < W; b++) begin
                if (clean_out[b] && !prev_clean[b]) up_at[b] = cyc;
                if (!clean_out[b] && prev_clean[b]) dn_at[b] = cyc;
                if (rise_pulse[b]) begin rise_hi[b]++; rise_at[b] = cyc; end
                if (fall_pulse[b]) begin fall_hi[b]++; fall_at[b] = cyc; end
            end
            if (rise_pulse != '0 && first_rise_cyc < 0) begin
                first_rise_vec = rise_pulse;
                first_rise_cyc = cyc;
            end
            prev_clean = clean_out;
        end
    endtask

    task automatic do_reset(input logic [W-1:0] raw_val);
        @(negedge clk);
        rst    = 1'b1;
        raw_in = raw_val;
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst    = 1'b1;
        raw_in = 5'b11111;
        repeat (3) @(negedge clk);
        checks++; if (clean_out !== 5'b00000) begin errors++; $display("FAIL reset_clean got %b exp 00000", clean_out); end
        checks++; if (rise_pulse !== 5'b00000) begin errors++; $display("FAIL reset_rise got %b exp 00000", rise_pulse); end
        checks++; if (fall_pulse !== 5'b00000) begin errors++; $display("FAIL reset_fall got %b exp 00000", fall_pulse); end
        rst    = 1'b0;
        raw_in = '0;
    endtask

    task automatic test_press();
        do_reset('0);
        raw_in = 5'b00001;
        step(20);
        checks++; if (up_at[0] != LAT) begin errors++; $display("FAIL press_clean_cycle got %0d exp %0d", up_at[0], LAT); end
        checks++; if (rise_hi[0] != 1) begin errors++; $display("FAIL press_rise_width got %0d exp 1", rise_hi[0]); end
        checks++; if (rise_at[0] != LAT + 1) begin errors++; $display("FAIL press_rise_cycle got %0d exp %0d", rise_at[0], LAT + 1); end
        checks++; if (clean_out !== 5'b00001) begin errors++; $display("FAIL press_clean got %b exp 00001", clean_out); end
    endtask

    task automatic test_bounce();
        do_reset('0);
        raw_in = 5'b00010; step(5);
        raw_in = 5'b00000; step(5);
        raw_in = 5'b00010; step(5);
        raw_in = 5'b00000; step(5);
        raw_in = 5'b00010; step(20);
        checks++; if (up_at[1] != BOUNCE_UP) begin errors++; $display("FAIL bounce_clean_cycle got %0d exp %0d", up_at[1], BOUNCE_UP); end
        checks++; if (rise_hi[1] != BOUNCE_RISES) begin errors++; $display("FAIL bounce_rise_count got %0d exp %0d", rise_hi[1], BOUNCE_RISES); end
        checks++; if (rise_at[1] != BOUNCE_UP + 1) begin errors++; $display("FAIL bounce_rise_cycle got %0d exp %0d", rise_at[1], BOUNCE_UP + 1); end
    endtask

    task automatic test_glitch();
        do_reset('0);
        raw_in = 5'b00100; step(8);
        raw_in = 5'b00000; step(4);
        checks++; if (clean_out[2] !== 1'b0) begin errors++; $display("FAIL glitch_clean got %b exp 0", clean_out[2]); end
        checks++; if (rise_hi[2] != GLITCH_RISES) begin errors++; $display("FAIL glitch_rise got %0d exp %0d", rise_hi[2], GLITCH_RISES); end
        checks++; if (fall_hi[2] != GLITCH_FALLS) begin errors++; $display("FAIL glitch_fall got %0d exp %0d", fall_hi[2], GLITCH_FALLS); end
        // a cleared counter needs three fresh ticks; a leftover count would accept at 16
        raw_in = 5'b00100; step(16);
        checks++; if (up_at[2] != GLITCH_UP) begin errors++; $display("FAIL glitch_repress_cycle got %0d exp %0d", up_at[2], GLITCH_UP); end
    endtask

    task automatic test_simultaneous();
        do_reset('0);
        raw_in = 5'b10101;
        step(20);
        checks++; if (first_rise_vec !== 5'b10101) begin errors++; $display("FAIL simul_rise_vec got %b exp 10101", first_rise_vec); end
        checks++; if (first_rise_cyc != LAT + 1) begin errors++; $display("FAIL simul_rise_cycle got %0d exp %0d", first_rise_cyc, LAT + 1); end
        checks++; if (rise_hi[4] != 1 || rise_hi[0] != 1 || rise_hi[2] != 1) begin errors++; $display("FAIL simul_rise_width got %0d/%0d/%0d exp 1/1/1", rise_hi[0], rise_hi[2], rise_hi[4]); end
        checks++; if (clean_out !== 5'b10101) begin errors++; $display("FAIL simul_clean got %b exp 10101", clean_out); end
    endtask

    task automatic test_reset_mid();
        do_reset('0);
        raw_in = 5'b01000;
        step(9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({clean_out, rise_pulse, fall_pulse} !== 15'd0) begin errors++; $display("FAIL midreset_outputs got %b/%b/%b exp all 0", clean_out, rise_pulse, fall_pulse); end
        clear_mon();
        step(20);
        checks++; if (up_at[3] != LAT) begin errors++; $display("FAIL midreset_clean_cycle got %0d exp %0d", up_at[3], LAT); end
        checks++; if (rise_hi[3] != 1) begin errors++; $display("FAIL midreset_rise_count got %0d exp 1", rise_hi[3]); end
    endtask

    task automatic test_held_through_reset();
        do_reset(5'b10000);
        checks++; if (clean_out !== 5'b00000) begin errors++; $display("FAIL held_clean_at_release got %b exp 00000", clean_out); end
        step(20);
        checks++; if (up_at[4] != LAT) begin errors++; $display("FAIL held_clean_cycle got %0d exp %0d", up_at[4], LAT); end
        checks++; if (rise_hi[4] != 1) begin errors++; $display("FAIL held_rise_count got %0d exp 1", rise_hi[4]); end
    endtask

    task automatic test_release();
        do_reset('0);
        raw_in = 5'b00001;
        step(20);
        // 20 cycles keeps the tick phase aligned, so the release latency equals the press latency
        clear_mon();
        raw_in = 5'b00000;
        step(20);
        checks++; if (dn_at[0] != LAT) begin errors++; $display("FAIL release_clean_cycle got %0d exp %0d", dn_at[0], LAT); end
        checks++; if (fall_hi[0] != 1) begin errors++; $display("FAIL release_fall_width got %0d exp 1", fall_hi[0]); end
        checks++; if (fall_at[0] != LAT + 1) begin errors++; $display("FAIL release_fall_cycle got %0d exp %0d", fall_at[0], LAT + 1); end
        checks++; if (rise_hi[0] != 0) begin errors++; $display("FAIL release_rise got %0d exp 0", rise_hi[0]); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_held_through_reset();
        test_release();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
